// File: rtl/ledr_fade_pkg.sv
// ledr_fade_pkg
//   Shared constants and types for the LEDR fade driver:
//     DEF_NUM_LEDS  - default number of LED channels
//     DEF_PWM_BITS  - default intensity width (MAX = 2^PWM_BITS-1)
//     DEF_PRESCALE  - default clk cycles per fade step
//     level_t       - intensity level type at the default width
//     presc_width() - counter width needed for a given prescale value
package ledr_fade_pkg;

  localparam int DEF_NUM_LEDS = 10;
  localparam int DEF_PWM_BITS = 4;
  localparam int DEF_PRESCALE = 50000;

  typedef logic [DEF_PWM_BITS-1:0] level_t;

  // Width of a counter spanning 0..prescale-1 (prescale >= 2).
  function automatic int presc_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/ledr_fade_channel.sv
// ledr_fade_channel
//   One LED channel: intensity level counter plus PWM comparator.
//   Optional fade-in: define LEDR_FADE_FADEIN_EN to ramp the level up one
//   step per step_tick instead of jumping straight to full brightness.
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   enable    in   1 = run, 0 = hold level and blank the output
//   step_tick in   one-cycle fade step strobe from the shared prescaler
//   led_req   in   requested LED state (target = MAX when 1, else 0)
//   pwm_cnt   in   shared free-running PWM counter
//   led_out   out  registered PWM drive for this LED
//   differs   out  combinational: level differs from target
module ledr_fade_channel
  import ledr_fade_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                step_tick,
  input  logic                led_req,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                differs
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

  logic [PWM_BITS-1:0] level_reg;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] target;

  assign target  = led_req ? LEVEL_MAX : '0;
  assign differs = (level_reg != target);

  // The target is taken from the current led_req, so a step_tick that lands
  // on the same cycle as a request change already moves toward the new target.
  always_comb begin
    level_next = level_reg;
    if (enable) begin
      if (led_req) begin
`ifdef LEDR_FADE_FADEIN_EN
        if (step_tick && (level_reg != LEVEL_MAX))
          level_next = level_reg + PWM_BITS'(1);
`else
        level_next = LEVEL_MAX;
`endif
      end else if (step_tick && (level_reg != '0)) begin
        level_next = level_reg - PWM_BITS'(1);
      end
    end
  end

  // Full level is forced on so MAX gives a solid LED rather than 15/16 duty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_reg <= '0;
      led_out   <= 1'b0;
    end else begin
      level_reg <= level_next;
      led_out   <= enable && ((level_reg == LEVEL_MAX) || (level_reg > pwm_cnt));
    end
  end

endmodule

// File: rtl/ledr_fade_driver.sv
// ledr_fade_driver
//   PWM fade driver for the board LEDR bank. A shared prescaler generates
//   step_tick every PRESCALE cycles and a shared PWM counter free-runs; each
//   channel fades its level toward the requested state.
//   Optional fade-in: define LEDR_FADE_FADEIN_EN (see ledr_fade_channel).
// Parameters:
//   NUM_LEDS  number of LED channels
//   PWM_BITS  intensity width, MAX = 2^PWM_BITS-1
//   PRESCALE  clk cycles per fade step, 2..2^24
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   enable   in   1 = run, 0 = freeze counters/levels and blank outputs
//   led_in   in   requested LED states from the LEDR PIO
//   led_out  out  registered PWM-dimmed LED drive
//   busy     out  registered: some channel level differs from its target
module ledr_fade_driver
  import ledr_fade_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       presc_reg;
  logic [PW-1:0]       presc_next;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_next;
  logic                step_tick;
  logic                busy_reg;
  logic [NUM_LEDS-1:0] differs;

  assign step_tick = enable && (presc_reg == PRESC_LAST);

  always_comb begin
    presc_next   = presc_reg;
    pwm_cnt_next = pwm_cnt_reg;
    if (enable) begin
      presc_next   = step_tick ? '0 : presc_reg + PW'(1);
      pwm_cnt_next = pwm_cnt_reg + PWM_BITS'(1);  // wraps MAX -> 0
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg   <= '0;
      pwm_cnt_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      presc_reg   <= presc_next;
      pwm_cnt_reg <= pwm_cnt_next;
      busy_reg    <= |differs;  // tracks even while enable=0
    end
  end

  assign busy = busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
      ledr_fade_channel #(
        .PWM_BITS(PWM_BITS)
      ) u_ch (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .step_tick(step_tick),
        .led_req  (led_in[gi]),
        .pwm_cnt  (pwm_cnt_reg),
        .led_out  (led_out[gi]),
        .differs  (differs[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ledr_fade_driver.sv
// tb_ledr_fade_driver
//   Table-driven bench for ledr_fade_driver (NUM_LEDS=10, PWM_BITS=4,
//   PRESCALE=4). A behavioural model predicts led_out/busy for every edge and
//   queues them; a negedge sampler pops and compares. Table records carry
//   hand-derived level[0]/busy expectations at sequence boundaries.
module tb_ledr_fade_driver;

  localparam int NL    = 10;
  localparam int PB    = 4;
  localparam int PRESC = 4;
  localparam int LMAX  = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NL-1:0] led_in;
  logic [NL-1:0] led_out;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  ledr_fade_driver #(
    .NUM_LEDS(NL),
    .PWM_BITS(PB),
    .PRESCALE(PRESC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .led_in (led_in),
    .led_out(led_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [NL-1:0] led;
    logic          busy;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("led_out", int'(led_out), int'(e.led));
      check("busy", int'(busy), int'(e.busy));
    end
  end

  // ---------------- reference model ----------------
  int m_lvl[NL];
  int m_presc;
  int m_pwm;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_lvl[i] = 0;
    m_presc = 0;
    m_pwm   = 0;
  endtask

  // Advance the model by one clock edge with the inputs seen at that edge.
  task automatic model_edge(input bit en, input logic [NL-1:0] led);
    exp_t e;
    bit   tick;
    tick   = en && (m_presc == PRESC - 1);
    e.busy = 1'b0;
    for (int i = 0; i < NL; i++) begin
      e.led[i] = en && ((m_lvl[i] == LMAX) || (m_lvl[i] > m_pwm));
      if (m_lvl[i] != (led[i] ? LMAX : 0)) e.busy = 1'b1;
    end
    if (en) begin
      for (int i = 0; i < NL; i++) begin
        if (led[i]) begin
`ifdef LEDR_FADE_FADEIN_EN
          if (tick && m_lvl[i] < LMAX) m_lvl[i]++;
`else
          m_lvl[i] = LMAX;
`endif
        end else if (tick && m_lvl[i] > 0) begin
          m_lvl[i]--;
        end
      end
      m_presc = tick ? 0 : m_presc + 1;
      m_pwm   = (m_pwm + 1) % (LMAX + 1);
    end
    sb_q.push_back(e);
  endtask

  // Apply inputs for one edge; called at posedge+1, returns at posedge+1.
  task automatic drive(input bit en, input logic [NL-1:0] led);
    enable = en;
    led_in = led;
    @(posedge clk);
    if (reset_n) model_edge(en, led);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            rst;   // pulse async reset before running
    bit            en;
    logic [NL-1:0] led;
    int            n;     // edges to run
    int            lvl;   // expected level[0] afterwards
    bit            bsy;   // expected busy afterwards
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input bit rst, input bit en, input logic [NL-1:0] led,
                              input int n, input int lvl, input bit bsy);
    vec_t v;
    v.rst = rst; v.en = en; v.led = led; v.n = n; v.lvl = lvl; v.bsy = bsy;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LEDR_FADE_FADEIN_EN
    vecs.push_back(mk(0, 1, 10'h001,  4,  1, 1));
    vecs.push_back(mk(0, 1, 10'h001, 56, 15, 1));
    vecs.push_back(mk(0, 1, 10'h001,  1, 15, 0));
    vecs.push_back(mk(0, 1, 10'h000, 38,  6, 1));
    vecs.push_back(mk(0, 1, 10'h001,  1,  7, 1));
    vecs.push_back(mk(0, 1, 10'h001, 32, 15, 1));
    vecs.push_back(mk(0, 1, 10'h001,  1, 15, 0));
    vecs.push_back(mk(0, 1, 10'h000, 64,  0, 0));
    vecs.push_back(mk(0, 1, 10'h3FF, 64, 15, 0));
    vecs.push_back(mk(0, 1, 10'h000, 40,  5, 1));
    vecs.push_back(mk(1, 1, 10'h3FF,  4,  1, 1));
    vecs.push_back(mk(0, 1, 10'h3FF,  4,  2, 1));
`else
    vecs.push_back(mk(0, 1, 10'h001,  1, 15, 1));  // load MAX next edge
    vecs.push_back(mk(0, 1, 10'h001,  3, 15, 0));
    vecs.push_back(mk(0, 1, 10'h000,  4, 14, 1));  // first fade step
    vecs.push_back(mk(0, 1, 10'h000, 20,  9, 1));
    vecs.push_back(mk(0, 0, 10'h000, 50,  9, 1));  // frozen, busy tracks
    vecs.push_back(mk(0, 1, 10'h000,  4,  8, 1));  // resumes from 9
    vecs.push_back(mk(0, 1, 10'h000,  8,  6, 1));
    vecs.push_back(mk(0, 1, 10'h000,  3,  6, 1));
    vecs.push_back(mk(0, 1, 10'h001,  1, 15, 1));  // re-assert on tick edge
    vecs.push_back(mk(0, 1, 10'h001, 32, 15, 0));
    vecs.push_back(mk(0, 1, 10'h001,  1, 15, 0));
    vecs.push_back(mk(0, 1, 10'h000, 64,  0, 0));  // full fade-out
    vecs.push_back(mk(0, 1, 10'h3FF, 64, 15, 0));
    vecs.push_back(mk(0, 1, 10'h000, 40,  5, 1));  // mid-fade at level 5
    vecs.push_back(mk(1, 1, 10'h3FF,  1, 15, 1));  // reset, then MAX
    vecs.push_back(mk(0, 1, 10'h3FF,  1, 15, 0));
`endif

    // reset state
    reset_n = 1'b0;
    enable  = 1'b1;
    led_in  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_led_out", int'(led_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_level0", int'(dut.g_ch[0].u_ch.level_reg), 0);
    reset_n = 1'b1;

    // first step_tick in the 4th cycle after release, then every 4
    for (int k = 0; k < 8; k++) begin
      check("step_tick", int'(dut.step_tick), (k % PRESC == PRESC - 1) ? 1 : 0);
      drive(1'b1, '0);
    end
    repeat (92) drive(1'b1, '0);
    $display("idle 100 cycles: level0=%0d busy=%0d", dut.g_ch[0].u_ch.level_reg, busy);

    foreach (vecs[v]) begin
      if (vecs[v].rst) begin
        enable = vecs[v].en;
        led_in = vecs[v].led;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_led_out", int'(led_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_level0", int'(dut.g_ch[0].u_ch.level_reg), 0);
        sb_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
      for (int c = 0; c < vecs[v].n; c++) drive(vecs[v].en, vecs[v].led);
      check($sformatf("vec%0d_level0", v), int'(dut.g_ch[0].u_ch.level_reg), vecs[v].lvl);
      check($sformatf("vec%0d_busy", v), int'(busy), int'(vecs[v].bsy));
      $display("vec %0d: rst=%0d en=%0d led_in=%03h n=%0d level0=%0d busy=%0d",
               v, vecs[v].rst, vecs[v].en, vecs[v].led, vecs[v].n,
               dut.g_ch[0].u_ch.level_reg, busy);
    end

    // let the scoreboard drain
    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ledr_fade_driver.md
LEDR_FADE_DRIVER -- requirements
Module: ledr_fade_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 10, number of LED channels.
REQ-002 SHALL have parameter PWM_BITS, default 4, intensity level width; MAX = 2^PWM_BITS-1.
REQ-003 SHALL have parameter PRESCALE, default 50000, clk cycles per fade step; legal range 2..2^24.
REQ-004 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  1 = run, 0 = freeze and blank outputs.
REQ-007 SHALL have port led_in  input  NUM_LEDS  requested LED state from the LEDR PIO out_port, same clk domain.
REQ-008 SHALL have port led_out  output  NUM_LEDS  PWM-dimmed drive to board LEDs, registered.
REQ-009 SHALL have port busy  output  1  registered; 1 while any channel level differs from its target.

Function
REQ-010 Prescaler SHALL count 0..PRESCALE-1 while enable=1, wrap to 0, and assert internal step_tick for exactly the cycle it equals PRESCALE-1.
REQ-011 PWM counter pwm_cnt (PWM_BITS wide) SHALL increment every cycle while enable=1, wrapping MAX->0.
REQ-012 Each channel SHALL hold level[i] (PWM_BITS wide); target = MAX if led_in[i]=1, else 0.
REQ-013 led_in[i]=0: level[i] SHALL decrement by 1 on each step_tick, saturating at 0 (fade-out over MAX ticks).
REQ-014 led_in[i]=1 (fade-in feature absent): level[i] SHALL load MAX on the next clk edge, irrespective of step_tick.
REQ-015 led_out[i] SHALL be registered as 1 when level[i]==MAX or level[i]>pwm_cnt, else 0; level 0 gives constant 0.
REQ-016 Latency: led_in[i] rising at edge N -> level[i]=MAX after edge N+1 -> led_out[i]=1 after edge N+2.
REQ-017 led_in[i] rising mid-fade-out SHALL abort the fade (REQ-014 or REQ-022 rule from current level); falling mid-fade-in SHALL start decrementing from current level.
REQ-018 step_tick coinciding with an led_in change SHALL use the new led_in value as target in that same cycle.
REQ-019 enable=0: prescaler, pwm_cnt and all levels SHALL hold; led_out SHALL be 0 from the next edge; busy SHALL keep tracking level vs target.
REQ-020 busy SHALL equal OR over channels of (level[i] != target[i]), registered one cycle.

Reset
REQ-021 reset_n low SHALL asynchronously clear prescaler, pwm_cnt, all levels, led_out and busy to 0; first step_tick occurs PRESCALE cycles after release with enable=1.

Configuration
REQ-022 Macro LEDR_FADE_FADEIN_EN defined: led_in[i]=1 SHALL increment level[i] by 1 per step_tick, saturating at MAX, instead of REQ-014.
REQ-023 Macro undefined: REQ-014 applies and no fade-in logic SHALL be synthesised; all other behaviour identical.

Structure
REQ-024 Package ledr_fade_pkg SHALL hold default NUM_LEDS, PWM_BITS, PRESCALE constants and level width typedef.
REQ-025 Per-channel level counter and comparator SHALL be sub-module ledr_fade_channel, instantiated NUM_LEDS times by generate; prescaler and pwm_cnt shared in the top.

Verification (bench: PRESCALE=4, PWM_BITS=4, NUM_LEDS=10)
REQ-026 Reset release, led_in=0, enable=1 -> led_out=0, busy=0 for 100 cycles; step_tick first at cycle 4.
REQ-027 led_in=10'h001 at edge N (macro off) -> level[0]=15 after N+1, led_out[0]=1 every cycle from N+2, busy high only cycle N+2.
REQ-028 From level 15, led_in=0 -> level[0] steps 15->0 over 15 ticks (60 cycles); at level 8, led_out[0] high 8 of every 16 cycles; busy drops after level 0.
REQ-029 Fade-out at level 6, led_in[0] re-asserted on a step_tick cycle -> level 15 next edge (macro off); macro on -> 7, then +1 per tick to 15 after 9 ticks.
REQ-030 enable=0 at level 9 for 50 cycles -> led_out=0, level stays 9; enable=1 -> fade resumes from 9.
REQ-031 reset_n pulsed low mid-fade (level 5, led_in=10'h3FF) -> all outputs 0 immediately; after release, all channels reach 15 one edge later (macro off).
